// File: rtl/sub_serial32_pkg.sv
// Shared constants for the slice-serial subtractor: default widths, derived
// slice count and index width, and the controller state encoding.
package sub_serial32_pkg;

   localparam int unsigned DefW      = 32;
   localparam int unsigned DefSliceW = 8;
   localparam int unsigned DefN      = DefW / DefSliceW;

   // Index counter width; at least one bit so a single-slice build still elaborates.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DefIdxW = idx_width(DefN);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/sub_slice.sv
// One slice of the subtractor: {co, s} = a + ~b + ci.
module sub_slice #(
   parameter int unsigned SLICE_W = 8
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);

   logic [SLICE_W:0] sum;

   // Widen every term so the carry out of the top bit is kept.
   always_comb begin
      sum = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, ci};
      s   = sum[SLICE_W-1:0];
      co  = sum[SLICE_W];
   end

endmodule

// File: rtl/sub_serial32.sv
// Multi-cycle subtractor d = a - b - bi, one slice per clock, LSB slice first,
// with start/done handshake and borrow, zero and signed-overflow flags.
module sub_serial32
   import sub_serial32_pkg::*;
#(
   parameter int unsigned W       = DefW,
   parameter int unsigned SLICE_W = DefSliceW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bi,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] d,
   output logic         bo,
   output logic         zero,
   output logic         ovf
);

   localparam int unsigned N    = W / SLICE_W;
   localparam int unsigned IdxW = idx_width(N);
   localparam logic [IdxW-1:0] LastK = IdxW'(N - 1);

   state_e            state;
   logic [W-1:0]      a_lat;
   logic [W-1:0]      b_lat;
   logic [W-1:0]      res;
   logic [W-1:0]      res_next;
   logic              carry;
   logic [IdxW-1:0]   k;
   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W-1:0] s_sl;
   logic               co_sl;

   // Select slice k of the latched operands for the shared slice unit.
   always_comb begin
      a_sl = a_lat[k*SLICE_W +: SLICE_W];
      b_sl = b_lat[k*SLICE_W +: SLICE_W];
   end

   sub_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .a  (a_sl),
      .b  (b_sl),
      .ci (carry),
      .s  (s_sl),
      .co (co_sl)
   );

   // Internal result with the current slice merged in, so the final slice can
   // be published to d on the same edge that enters DONE.
   always_comb begin
      res_next = res;
      res_next[k*SLICE_W +: SLICE_W] = s_sl;
   end

   // Controller FSM with registered handshake outputs and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= StIdle;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bo    <= 1'b0;
         zero  <= 1'b0;
         ovf   <= 1'b0;
         a_lat <= '0;
         b_lat <= '0;
         res   <= '0;
         carry <= 1'b0;
         k     <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  a_lat <= a;
                  b_lat <= b;
                  carry <= ~bi;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= StCalc;
               end
            end
            StCalc: begin
               res   <= res_next;
               carry <= co_sl;
               k     <= k + 1'b1;
               if (k == LastK) begin
                  state <= StDone;
                  done  <= 1'b1;
                  d     <= res_next;
                  bo    <= ~co_sl;
                  zero  <= (res_next == '0);
                  ovf   <= (a_lat[W-1] != b_lat[W-1]) && (res_next[W-1] != a_lat[W-1]);
               end
            end
            StDone: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_serial32.sv
// Directed self-checking bench for sub_serial32 at default widths.
module tb_sub_serial32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        bi;
   logic        busy;
   logic        done;
   logic [31:0] d;
   logic        bo;
   logic        zero;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sub_serial32 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo),
      .zero  (zero),
      .ovf   (ovf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation; returns the cycle in which done rose (accept cycle = 1)
   // and how many of those cycles had busy high.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic biv,
                        output int lat, output int busy_cnt);
      a = av; b = bv; bi = biv; start = 1'b1;
      step();
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         step();
         lat++;
      end
      if (busy) busy_cnt++;
   endtask

   // Run one operation and check result and flags.
   task automatic op_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic biv, input logic [31:0] exp_d, input logic exp_bo,
                           input logic exp_zero, input logic exp_ovf);
      int lat;
      int bc;
      do_op(av, bv, biv, lat, bc);
      check_eq({tag, "_lat"}, lat, 5);
      check_eq({tag, "_d"}, d, exp_d);
      check_eq({tag, "_bo"}, {31'd0, bo}, {31'd0, exp_bo});
      check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
      check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      step();
   endtask

   initial begin
      int lat;
      int bc;
      int dones;
      int stable;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_d", d, 32'd0);
      check_eq("rst_flags", {29'd0, bo, zero, ovf}, 32'd0);

      // Basic 5 - 3 with latency and busy window.
      do_op(32'd5, 32'd3, 1'b0, lat, bc);
      check_eq("basic_lat", lat, 5);
      check_eq("basic_busy_cycles", bc, 5);
      check_eq("basic_d", d, 32'h0000_0002);
      check_eq("basic_flags", {29'd0, bo, zero, ovf}, 32'd0);
      step();
      check_eq("basic_done_pulse", {31'd0, done}, 32'd0);
      check_eq("basic_busy_after", {31'd0, busy}, 32'd0);

      op_check("neg", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
      op_check("slice_borrow", 32'h0000_0100, 32'd1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
      op_check("ovf_min", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
      op_check("ovf_max", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
      op_check("eq_bi0", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
      op_check("eq_bi1", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

      // Start during CALC must be ignored.
      a = 32'd9; b = 32'd4; bi = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a = 32'd0; b = 32'd1; start = 1'b1;
      step();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) dones++;
         step();
      end
      check_eq("ignore_done_count", dones, 1);
      check_eq("ignore_d", d, 32'd5);
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         if (d !== 32'd5 || done) stable = 0;
         step();
      end
      check_eq("ignore_hold", stable, 1);

      // Reset on the second CALC cycle aborts the operation.
      a = 32'd7; b = 32'd2; bi = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_done", {31'd0, done}, 32'd0);
      check_eq("abort_d", d, 32'd0);
      check_eq("abort_flags", {29'd0, bo, zero, ovf}, 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) dones++;
         step();
      end
      check_eq("abort_no_done", dones, 0);
      op_check("after_abort", 32'd10, 32'd10, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
